piezo_tone_gen: RTL and testbench

- Downstream output stage of the lock controller; consumes its event pulses and drives the Piezo pin.
- Converts three one-cycle request pulses into audible patterns:
  - key: 1 short high beep
  - ok: 2 short high beeps
  - err: 3 long low beeps
- Replaces direct level drive of Piezo with a square-wave tone generator, a beep sequencer and a busy flag.

---
 rtl/lock_pkg.sv | 40 ++++
 rtl/tone_div.sv | 33 +++
 rtl/piezo_tone_gen.sv | 134 +++++++++++++
 tb/tb_piezo_tone_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types for the lock controller output stage: sequencer states and
// beep pattern encoding.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic {
        SEL_HI = 1'b0,
        SEL_LO = 1'b1
    } tone_sel_t;

    localparam int unsigned BEEP_W = 2;

    localparam logic [BEEP_W-1:0] BEEPS_KEY = BEEP_W'(1);
    localparam logic [BEEP_W-1:0] BEEPS_OK  = BEEP_W'(2);
    localparam logic [BEEP_W-1:0] BEEPS_ERR = BEEP_W'(3);

    typedef struct packed {
        tone_sel_t         tone;
        logic              long_len;
        logic [BEEP_W-1:0] beeps;
    } pattern_t;

    // Priority err > ok > key; a key-only request falls through to the default.
    function automatic pattern_t pick_pattern(input logic ok, input logic err);
        pattern_t p;
        p = '{tone: SEL_HI, long_len: 1'b0, beeps: BEEPS_KEY};
        if (err) begin
            p = '{tone: SEL_LO, long_len: 1'b1, beeps: BEEPS_ERR};
        end else if (ok) begin
            p = '{tone: SEL_HI, long_len: 1'b0, beeps: BEEPS_OK};
        end
        return p;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: toggles o_wave every i_half enabled cycles; held at 0
// with phase cleared whenever i_en is low.
module tone_div #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_half,
    input  logic             i_en,
    output logic             o_wave
);

    logic [CNT_W-1:0] r_phase;
    logic             r_wave;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_wave  <= 1'b0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_wave  <= 1'b0;
        end else if (r_phase == i_half - 1'b1) begin
            r_phase <= '0;
            r_wave  <= ~r_wave;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/piezo_tone_gen.sv
// Beep sequencer for the lock controller: turns key/ok/err pulses into tone
// patterns on Piezo, with busy and a completion pulse.
module piezo_tone_gen
    import lock_pkg::*;
#(
    parameter int unsigned HALF_HI   = 4,
    parameter int unsigned HALF_LO   = 8,
    parameter int unsigned SHORT_LEN = 64,
    parameter int unsigned LONG_LEN  = 128,
    parameter int unsigned GAP_LEN   = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic beep_key,
    input  logic beep_ok,
    input  logic beep_err,
    output logic Piezo,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] HALF_HI_W  = CNT_W'(HALF_HI);
    localparam logic [CNT_W-1:0] HALF_LO_W  = CNT_W'(HALF_LO);

    state_t            r_state;
    logic [CNT_W-1:0]  r_dur;
    logic [BEEP_W-1:0] r_beeps;
    tone_sel_t         r_tone;
    logic              r_long;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_dur_nxt;
    logic [BEEP_W-1:0] w_beeps_nxt;
    tone_sel_t         w_tone_nxt;
    logic              w_long_nxt;
    logic              w_done_nxt;
    logic [CNT_W-1:0]  w_len_last;
    logic [CNT_W-1:0]  w_half;
    logic              w_tone_en;
    pattern_t          w_pat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_dur   <= '0;
            r_beeps <= '0;
            r_tone  <= SEL_HI;
            r_long  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dur   <= w_dur_nxt;
            r_beeps <= w_beeps_nxt;
            r_tone  <= w_tone_nxt;
            r_long  <= w_long_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_beeps_nxt = r_beeps;
        w_tone_nxt  = r_tone;
        w_long_nxt  = r_long;
        w_done_nxt  = 1'b0;
        w_pat       = pick_pattern(beep_ok, beep_err);
        w_len_last  = r_long ? LONG_LAST : SHORT_LAST;

        case (r_state)
            IDLE: begin
                if (beep_key || beep_ok || beep_err) begin
                    w_state_nxt = TONE;
                    w_dur_nxt   = '0;
                    w_tone_nxt  = w_pat.tone;
                    w_long_nxt  = w_pat.long_len;
                    w_beeps_nxt = w_pat.beeps;
                end
            end
            TONE: begin
                if (r_dur == w_len_last) begin
                    w_dur_nxt   = '0;
                    w_beeps_nxt = r_beeps - 1'b1;
                    if (r_beeps == BEEP_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = GAP;
                    end
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            GAP: begin
                if (r_dur == GAP_LAST) begin
                    w_dur_nxt   = '0;
                    w_state_nxt = TONE;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dur_nxt   = '0;
            end
        endcase
    end

    // Dropping enable on the last tone cycle forces Piezo low on the exit edge.
    assign w_tone_en = (r_state == TONE) && (r_dur != w_len_last);
    assign w_half    = (r_tone == SEL_LO) ? HALF_LO_W : HALF_HI_W;

    tone_div #(
        .CNT_W (CNT_W)
    ) u_tone_div (
        .clk    (clk),
        .rst    (rst),
        .i_half (w_half),
        .i_en   (w_tone_en),
        .o_wave (Piezo)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Scoreboard bench for piezo_tone_gen: expected patterns are queued at issue
// time and checked per busy episode by an independent monitor.
module tb_piezo_tone_gen;

    localparam int HALF_HI   = 4;
    localparam int HALF_LO   = 8;
    localparam int SHORT_LEN = 64;
    localparam int LONG_LEN  = 128;
    localparam int GAP_LEN   = 32;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic beep_key = 1'b0;
    logic beep_ok  = 1'b0;
    logic beep_err = 1'b0;
    logic Piezo;
    logic busy;
    logic done;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int n;
        int half;
        int len;
    } exp_t;

    exp_t sb[$];

    piezo_tone_gen dut (
        .clk      (clk),
        .rst      (rst),
        .beep_key (beep_key),
        .beep_ok  (beep_ok),
        .beep_err (beep_err),
        .Piezo    (Piezo),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: which pattern a request set produces, from the priority rule.
    function automatic exp_t model(input logic k, input logic o, input logic e);
        exp_t x;
        x = '{n: 0, half: 0, len: 0};
        if (e)      x = '{n: 3, half: HALF_LO, len: LONG_LEN};
        else if (o) x = '{n: 2, half: HALF_HI, len: SHORT_LEN};
        else if (k) x = '{n: 1, half: HALF_HI, len: SHORT_LEN};
        return x;
    endfunction

    function automatic int busy_len(input exp_t x);
        return x.n * x.len + (x.n - 1) * GAP_LEN;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; returns after the negedge following the sample edge.
    task automatic issue(input logic k, input logic o, input logic e, output int dur);
        exp_t x;
        x = model(k, o, e);
        if (x.n > 0) sb.push_back(x);
        dur = busy_len(x);
        beep_key = k; beep_ok = o; beep_err = e;
        @(negedge clk);
        beep_key = 1'b0; beep_ok = 1'b0; beep_err = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] r);
        beep_key = r[0]; beep_ok = r[1]; beep_err = r[2];
        @(negedge clk);
        beep_key = 1'b0; beep_ok = 1'b0; beep_err = 1'b0;
    endtask

    // Plays one pattern, optionally firing an ignored request at edge k+ign_at.
    task automatic play(input logic [2:0] r, input int ign_at, input logic [2:0] ign);
        int dur;
        issue(r[0], r[1], r[2], dur);
        if (ign_at > 0 && ign_at <= dur) begin
            cycles(ign_at - 1);
            pulse(ign);
            cycles(dur - ign_at);
        end else begin
            cycles(dur);
        end
    endtask

    initial begin : monitor
        bit   active;
        bit   ended;
        int   t;
        int   high;
        int   per;
        logic prev_p;
        int   rises[$];
        int   exp_rises[$];
        exp_t e;
        active = 1'b0;
        t      = 0;
        high   = 0;
        prev_p = 1'b0;
        forever begin
            @(negedge clk);
            ended = 1'b0;
            if (!rst) begin
                active = 1'b0;
                prev_p = 1'b0;
            end else begin
                if (busy) begin
                    if (!active) begin
                        active = 1'b1;
                        t      = 0;
                        high   = 0;
                        rises.delete();
                    end
                    if (Piezo && !prev_p) rises.push_back(t);
                    if (Piezo) high++;
                    t++;
                end else begin
                    if (active) begin
                        ended  = 1'b1;
                        active = 1'b0;
                        chk("done_at_end", int'(done), 1);
                        chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                        if (sb.size() > 0) begin
                            e   = sb.pop_front();
                            per = e.len / (2 * e.half);
                            chk("busy_cycles", t, busy_len(e));
                            chk("rise_count", rises.size(), e.n * per);
                            chk("high_cycles", high, e.n * e.len / 2);
                            exp_rises.delete();
                            for (int b = 0; b < e.n; b++)
                                for (int j = 0; j < per; j++)
                                    exp_rises.push_back(b * (e.len + GAP_LEN) + e.half + 2 * e.half * j);
                            if (rises.size() == exp_rises.size())
                                foreach (rises[i]) chk("rise_time", rises[i], exp_rises[i]);
                        end
                    end
                    chk("piezo_idle", int'(Piezo), 0);
                end
                if (!ended) chk("done_low", int'(done), 0);
                prev_p = Piezo;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          dur;
        logic [2:0]  r;
        logic [2:0]  ign;
        int          ign_at;
        exp_t        x;

        // Reset held with a pending err request: everything stays quiet.
        rst      = 1'b0;
        beep_err = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_piezo", int'(Piezo), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
        end
        beep_err = 1'b0;
        rst      = 1'b1;
        cycles(20);
        chk("idle_after_rst", int'(busy), 0);

        // Directed patterns.
        play(3'b001, 0, 3'b000);
        cycles(3);
        play(3'b010, 0, 3'b000);
        cycles(2);
        play(3'b101, 0, 3'b000);
        cycles(5);

        // ok pattern with err during TONE (edge k+20) and key during GAP (edge k+70).
        issue(1'b0, 1'b1, 1'b0, dur);
        cycles(19);
        pulse(3'b100);
        cycles(49);
        pulse(3'b001);
        cycles(dur - 70);
        cycles(10);

        // Reset 40 cycles into an err pattern: outputs drop at once, no done.
        issue(1'b0, 1'b0, 1'b1, dur);
        cycles(39);
        rst = 1'b0;
        #1;
        chk("abort_piezo", int'(Piezo), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        sb.delete();
        cycles(3);
        rst = 1'b1;
        cycles(10);
        play(3'b001, 0, 3'b000);
        cycles(4);

        // Randomized requests, some with an ignored request mid-pattern.
        for (int it = 0; it < 16; it++) begin
            r   = 3'($urandom_range(1, 7));
            ign = 3'($urandom_range(1, 7));
            x   = model(r[0], r[1], r[2]);
            ign_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, busy_len(x))) : 0;
            play(r, ign_at, ign);
            cycles(int'($urandom_range(0, 4)));
        end

        cycles(20);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
